score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Scoring stage downstream of the light rows. Conditions raw row buttons into
//  one-cycle user_input pulses for the rows, judges hits against each row's top
//  light, counts misses from off_edge, and keeps a saturating score and combo.
//  Drives stop (score == max) back to every row and to the display logic.
// PARAMETERS
//  NUM_ROWS  4  number of light rows / buttons
//  SCORE_W   8  score width; max score = 2**SCORE_W-1 (255)
//  COMBO_TH  8  combo value at/above which a hit scores 2 instead of 1
// PORTS
//  clk         in   1         system clock
//  reset_n     in   1         asynchronous, active-low reset
//  key_raw     in   NUM_ROWS  raw (asynchronous) row buttons, active-high
//  top_light   in   NUM_ROWS  lightOn[0] of each row
//  off_edge    in   NUM_ROWS  offEdge of each row (level, updated once per step)
//  row_tick    in   1         1-cycle pulse, cycle after rows shift (counter wrap)
//  user_input  out  NUM_ROWS  1-cycle press pulses to rows
//  score       out  SCORE_W   current score
//  combo       out  8         consecutive hits, saturates at 255
//  playing     out  1         high in PLAY
//  stop        out  1         high in DONE
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, state IDLE, sync flops 0,
//   hit_lock 0.
//  Conditioning per row: 2-flop synchroniser, then rising-edge detect into a
//   registered pulse. user_input[i] is high for exactly 1 cycle; it starts on
//   the 3rd clk edge after key_raw[i] is first sampled high. Holding the key
//   gives one pulse only. Pulses are forwarded in every state.
//  Judging (PLAY only), evaluated per cycle, per row:
//   hit[i]  = user_input[i] & top_light[i] & ~hit_lock[i]; sets hit_lock[i]
//   miss[i] = row_tick & off_edge[i]
//   press with top_light[i]=0, or while locked: ignored (no score/combo change)
//   row_tick clears every hit_lock bit. If it coincides with a hit, the hit
//   still sets hit_lock for the new step.
//  Arithmetic, one update per cycle, all rows summed:
//   pts = sum over hits of (combo >= COMBO_TH ? 2 : 1), using pre-update combo.
//   Compute pts at SCORE_W+3 bits; score_next = min(score + pts, max).
//   Any miss that cycle: combo <= 0; hits in the same cycle are still scored.
//   Else combo <= sat255(combo + number of hits).
//  FSM:
//   IDLE -> PLAY: any user_input pulse. That press is not judged.
//   PLAY -> DONE: on the edge where score_next == max.
//   DONE: score and combo frozen, stop=1, held until reset_n.
//  Outputs: playing = (state == PLAY); stop = (state == DONE); all registered.
//  Latency: user_input pulse to score update is 1 edge.
//  Reset mid-game: everything clears immediately; no partial update.
// CONFIGURATION
//  SCORE_PENALTY_EN defined:
//   each miss[i] also subtracts 1.
//   score_next = clamp(score + pts - misses, 0, max), evaluated with signed
//   SCORE_W+4-bit arithmetic.
//  SCORE_PENALTY_EN undefined: misses only clear combo; score never decreases.
// TESTING
//  1 reset_n=0 mid-PLAY with score=37 -> next sample: score=0, combo=0,
//    state IDLE, stop=0, user_input=0.
//  2 key_raw[2] held high 10 cycles -> exactly one user_input[2] pulse, at
//    edge 3.
//    From IDLE it moves to PLAY and score stays 0.
//  3 PLAY, top_light[0]=1, press row0 twice in one step -> score +1 once.
//    After row_tick, a press scores again.
//  4 combo=8, hits on rows 0 and 1 in the same cycle -> score +4, combo=10.
//  5 row_tick with off_edge[3]=1, combo=5, score=20 -> combo=0; score=20
//    (penalty off) or 19 (SCORE_PENALTY_EN).
//    With penalty on and score=0 -> score stays 0.
//  6 score=254, combo>=8, single hit -> score=255, stop=1, playing=0.
//    Later presses leave score=255.

Source files
------------

// File: rtl/score_keeper.sv
// Scoring stage: conditions row buttons into press pulses, judges hits against
// each row's top light, and keeps a saturating score and combo. Option: SCORE_PENALTY_EN.
module score_keeper #(
    parameter int unsigned NUM_ROWS = 4,
    parameter int unsigned SCORE_W  = 8,
    parameter int unsigned COMBO_TH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_ROWS-1:0] key_raw,
    input  logic [NUM_ROWS-1:0] top_light,
    input  logic [NUM_ROWS-1:0] off_edge,
    input  logic                row_tick,
    output logic [NUM_ROWS-1:0] user_input,
    output logic [SCORE_W-1:0]  score,
    output logic [7:0]          combo,
    output logic                playing,
    output logic                stop
);

    localparam int unsigned CNT_W   = $clog2(NUM_ROWS + 1);
    localparam int unsigned PTS_W   = SCORE_W + 3;
    localparam int unsigned COMBO_W = 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [NUM_ROWS-1:0] sync1;
    logic [NUM_ROWS-1:0] sync2;
    logic [NUM_ROWS-1:0] sync2_d;
    logic [NUM_ROWS-1:0] hit_lock;
    logic [NUM_ROWS-1:0] lock_next;
    logic [NUM_ROWS-1:0] hit;
    logic [NUM_ROWS-1:0] miss;
    logic [CNT_W-1:0]    n_hits;
    logic [PTS_W-1:0]    pts;
    logic [SCORE_W-1:0]  score_next;
    logic [COMBO_W-1:0]  combo_next;
    logic [COMBO_W:0]    combo_sum;
    logic                in_play;

`ifdef SCORE_PENALTY_EN
    localparam int unsigned SGN_W = SCORE_W + 4;
    logic [CNT_W-1:0]        n_miss;
    logic signed [SGN_W-1:0] score_sum;
`else
    logic [PTS_W-1:0]        score_sum;
`endif

    // Two-flop synchroniser plus rising-edge detect into a registered pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            sync2_d    <= '0;
            user_input <= '0;
        end else begin
            sync1      <= key_raw;
            sync2      <= sync1;
            sync2_d    <= sync2;
            user_input <= sync2 & ~sync2_d;
        end
    end

    // Hit/miss judging and next score/combo for this cycle
    always_comb begin
        in_play = (state == PLAY);
        hit     = in_play ? (user_input & top_light & ~hit_lock) : '0;
        miss    = (in_play && row_tick) ? off_edge : '0;
        n_hits  = '0;
`ifdef SCORE_PENALTY_EN
        n_miss  = '0;
`endif
        for (int i = 0; i < NUM_ROWS; i++) begin
            n_hits = n_hits + CNT_W'(hit[i]);
`ifdef SCORE_PENALTY_EN
            n_miss = n_miss + CNT_W'(miss[i]);
`endif
        end

        // Combo is judged before this cycle's update
        pts = (combo >= COMBO_W'(COMBO_TH)) ? PTS_W'({n_hits, 1'b0}) : PTS_W'(n_hits);

`ifdef SCORE_PENALTY_EN
        score_sum = $signed(SGN_W'(score)) + $signed(SGN_W'(pts)) - $signed(SGN_W'(n_miss));
        if (score_sum < 0) begin
            score_next = '0;
        end else if (score_sum > $signed(SGN_W'(SCORE_MAX))) begin
            score_next = SCORE_MAX;
        end else begin
            score_next = SCORE_W'(score_sum);
        end
`else
        score_sum  = PTS_W'(score) + pts;
        score_next = (score_sum > PTS_W'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(score_sum);
`endif

        combo_sum = (COMBO_W + 1)'(combo) + (COMBO_W + 1)'(n_hits);
        if (|miss) begin
            combo_next = '0;
        end else if (combo_sum[COMBO_W]) begin
            combo_next = COMBO_MAX;
        end else begin
            combo_next = combo_sum[COMBO_W-1:0];
        end

        // A hit landing on the tick still locks its row for the new step
        lock_next = (row_tick ? '0 : hit_lock) | hit;
    end

    // Game FSM with registered score, combo and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            score    <= '0;
            combo    <= '0;
            playing  <= 1'b0;
            stop     <= 1'b0;
            hit_lock <= '0;
        end else begin
            hit_lock <= lock_next;
            case (state)
                IDLE: begin
                    if (|user_input) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end
                end
                PLAY: begin
                    score <= score_next;
                    combo <= combo_next;
                    if (score_next == SCORE_MAX) begin
                        state   <= DONE;
                        playing <= 1'b0;
                        stop    <= 1'b1;
                    end
                end
                DONE: begin
                    stop <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    playing <= 1'b0;
                    stop    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: conditioning, judging, combo bonus, misses,
// mid-game reset and saturation into DONE.
module tb_score_keeper;

    logic       clk;
    logic       reset_n;
    logic [3:0] key_raw;
    logic [3:0] top_light;
    logic [3:0] off_edge;
    logic       row_tick;
    logic [3:0] user_input;
    logic [7:0] score;
    logic [7:0] combo;
    logic       playing;
    logic       stop;

    int errors = 0;
    int checks = 0;

`ifdef SCORE_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    score_keeper dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_raw    (key_raw),
        .top_light  (top_light),
        .off_edge   (off_edge),
        .row_tick   (row_tick),
        .user_input (user_input),
        .score      (score),
        .combo      (combo),
        .playing    (playing),
        .stop       (stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold a key long enough for one pulse, then release until the synchroniser is clear
    task automatic press(input logic [3:0] m);
        @(negedge clk) key_raw = m;
        repeat (3) @(posedge clk);
        @(negedge clk) key_raw = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick(input logic [3:0] off);
        @(negedge clk);
        row_tick = 1'b1;
        off_edge = off;
        @(posedge clk);
        @(negedge clk);
        row_tick = 1'b0;
        off_edge = '0;
    endtask

    initial begin
        int pulses;
        int pulse_edge;

        reset_n   = 1'b0;
        key_raw   = '0;
        top_light = '0;
        off_edge  = '0;
        row_tick  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_score", score, 0);
        chk("reset_combo", combo, 0);
        chk("reset_playing", playing, 0);
        chk("reset_stop", stop, 0);
        chk("reset_user_input", user_input, 0);
        reset_n = 1'b1;

        // Held key gives exactly one pulse on edge 3; starting press is not judged
        top_light = 4'hF;
        pulses = 0;
        pulse_edge = 0;
        @(negedge clk) key_raw = 4'b0100;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (user_input[2]) begin
                pulses++;
                pulse_edge = e;
            end
        end
        chk("hold_pulse_count", pulses, 1);
        chk("hold_pulse_edge", pulse_edge, 3);
        @(negedge clk) key_raw = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("start_playing", playing, 1);
        chk("start_score", score, 0);
        chk("start_combo", combo, 0);

        // Lock within a step, ignored dark-row press, relock after tick
        top_light = 4'b0001;
        press(4'b0001);
        chk("first_hit_score", score, 1);
        chk("first_hit_combo", combo, 1);
        press(4'b0001);
        chk("locked_score", score, 1);
        chk("locked_combo", combo, 1);
        tick(4'b0000);
        press(4'b0010);
        chk("dark_row_score", score, 1);
        press(4'b0001);
        chk("relock_hit_score", score, 2);
        chk("relock_hit_combo", combo, 2);

        // Combo bonus starts once combo reaches 8
        top_light = 4'hF;
        tick(4'b0000);
        press(4'hF);
        chk("quad_hit_score", score, 6);
        chk("quad_hit_combo", combo, 6);
        tick(4'b0000);
        press(4'b0011);
        chk("pre_bonus_score", score, 8);
        chk("pre_bonus_combo", combo, 8);
        tick(4'b0000);
        press(4'b0011);
        chk("bonus_score", score, 12);
        chk("bonus_combo", combo, 10);

        // Miss clears combo; penalty build also subtracts
        tick(4'b1000);
        chk("miss_combo", combo, 0);
        chk("miss_score", score, 12 - PEN);

        // Asynchronous reset mid-game
        @(negedge clk) reset_n = 1'b0;
        #1;
        chk("midreset_score", score, 0);
        chk("midreset_combo", combo, 0);
        chk("midreset_playing", playing, 0);
        chk("midreset_stop", stop, 0);
        chk("midreset_user_input", user_input, 0);
        @(negedge clk) reset_n = 1'b1;

        press(4'b0001);
        chk("restart_playing", playing, 1);
        chk("restart_score", score, 0);
        tick(4'b1000);
        chk("miss_at_zero_score", score, 0);
        chk("miss_at_zero_combo", combo, 0);

        // Climb to 254, then a bonus hit saturates at 255 and ends the game
        tick(4'b0000);
        press(4'hF);
        chk("climb1_score", score, 4);
        tick(4'b0000);
        press(4'hF);
        chk("climb2_score", score, 8);
        for (int k = 0; k < 30; k++) begin
            tick(4'b0000);
            press(4'hF);
            chk("climb_loop_score", score, 16 + 8 * k);
        end
        chk("climb_combo", combo, 128);
        for (int k = 0; k < 3; k++) begin
            tick(4'b0000);
            press(4'b0001);
        end
        chk("near_max_score", score, 254);
        chk("near_max_stop", stop, 0);
        chk("near_max_playing", playing, 1);
        tick(4'b0000);
        press(4'b0001);
        chk("max_score", score, 255);
        chk("max_stop", stop, 1);
        chk("max_playing", playing, 0);
        chk("max_combo", combo, 132);

        tick(4'hF);
        press(4'hF);
        chk("done_score", score, 255);
        chk("done_combo", combo, 132);
        chk("done_stop", stop, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
